// File: rtl/insn_seq_ctrl.sv
// rtl/insn_seq_ctrl.sv - instruction-fetch sequencer: sequential fetch, jump redirect with flush, halt/resume
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   stall_i        fetcher cannot accept an address this cycle (holds the increment in RUN only)
//   jump_valid_i   taken jump pulse from execute
//   jump_abs_i     1 = absolute target (JA), 0 = pc-relative (J)
//   jump_pc_i      address of the jump instruction
//   jump_imm_i     absolute target, or signed offset for J
//   halt_i         HLT reached execute, pulse
//   resume_i       leave HALT
//   addr_o         registered fetch address
//   fetch_valid_o  addr_o is a real fetch request
//   flush_o        kill in-flight decode/execute contents
//   halted_o       controller is in HALT
module insn_seq_ctrl #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR   = '0,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              jump_valid_i,
    input  logic              jump_abs_i,
    input  logic [ADDR_W-1:0] jump_pc_i,
    input  logic [ADDR_W-1:0] jump_imm_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Counter holds the number of FLUSH cycles still to go after the current one.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [ADDR_W-1:0] target;

    // Relative add wraps naturally at ADDR_W bits; a negative offset is just its two's complement.
    assign target = jump_abs_i ? jump_imm_i : (jump_pc_i + jump_imm_i);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_o;
        unique case (state)
            ST_RUN, ST_FLUSH: begin
                if (halt_i) begin
                    // Halt wins over a same-cycle jump; the address freezes where it is.
                    state_nx = ST_HALT;
                end else if (jump_valid_i) begin
                    state_nx = ST_FLUSH;
                    addr_nx  = target;
                    cnt_nx   = FLUSH_LOAD;
                end else if (state == ST_RUN) begin
                    if (!stall_i) begin
                        addr_nx = addr_o + ADDR_ONE;
                    end
                end else if (cnt == 4'd0) begin
                    // Leave FLUSH without incrementing so the target itself is fetched first.
                    state_nx = ST_RUN;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_RUN;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_RUN;
            cnt           <= 4'd0;
            addr_o        <= RESET_ADDR;
            fetch_valid_o <= 1'b1;
            flush_o       <= 1'b0;
            halted_o      <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            addr_o        <= addr_nx;
            fetch_valid_o <= (state_nx == ST_RUN);
            flush_o       <= (state_nx == ST_FLUSH);
            halted_o      <= (state_nx == ST_HALT);
        end
    end

endmodule

// File: tb/tb_insn_seq_ctrl.sv
// tb/tb_insn_seq_ctrl.sv - directed self-checking bench for insn_seq_ctrl
module tb_insn_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_valid_i;
    logic        jump_abs_i;
    logic [15:0] jump_pc_i;
    logic [15:0] jump_imm_i;
    logic        halt_i;
    logic        resume_i;
    logic [15:0] addr_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        halted_o;

    int tests  = 0;
    int failed = 0;

    insn_seq_ctrl #(
        .ADDR_W      (16),
        .RESET_ADDR  (16'h0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_valid_i (jump_valid_i),
        .jump_abs_i   (jump_abs_i),
        .jump_pc_i    (jump_pc_i),
        .jump_imm_i   (jump_imm_i),
        .halt_i       (halt_i),
        .resume_i     (resume_i),
        .addr_o       (addr_o),
        .fetch_valid_o(fetch_valid_o),
        .flush_o      (flush_o),
        .halted_o     (halted_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full output vector {addr, fetch_valid, flush, halted}.
    task automatic check_all(input string tag, input logic [15:0] a, input logic fv,
                             input logic fl, input logic h);
        check({tag, ".addr"}, {16'h0, addr_o}, {16'h0, a});
        check({tag, ".fv"}, {31'h0, fetch_valid_o}, {31'h0, fv});
        check({tag, ".flush"}, {31'h0, flush_o}, {31'h0, fl});
        check({tag, ".halted"}, {31'h0, halted_o}, {31'h0, h});
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic abs_t, input logic [15:0] pc, input logic [15:0] imm);
        jump_valid_i = 1'b1;
        jump_abs_i   = abs_t;
        jump_pc_i    = pc;
        jump_imm_i   = imm;
        step();
        jump_valid_i = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        stall_i      = 1'b0;
        jump_valid_i = 1'b0;
        jump_abs_i   = 1'b0;
        jump_pc_i    = 16'h0;
        jump_imm_i   = 16'h0;
        halt_i       = 1'b0;
        resume_i     = 1'b0;
        step();
        step();
        check_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;

        // Sequential fetch from reset address
        for (int i = 0; i < 5; i++) begin
            check_all($sformatf("seq%0d", i), 16'(i), 1'b1, 1'b0, 1'b0);
            step();
        end

        // J relative: 0x0010 + 0xFFFC = 0x000C
        jump(1'b0, 16'h0010, 16'hFFFC);
        check_all("j_f1", 16'h000C, 1'b0, 1'b1, 1'b0);
        step();
        check_all("j_f2", 16'h000C, 1'b0, 1'b1, 1'b0);
        step();
        check_all("j_run", 16'h000C, 1'b1, 1'b0, 1'b0);
        step();
        check_all("j_inc", 16'h000D, 1'b1, 1'b0, 1'b0);

        // JA arriving one cycle into FLUSH re-enters FLUSH: 3 flush cycles total
        jump(1'b0, 16'h0010, 16'hFFFC);
        check_all("ja_f1", 16'h000C, 1'b0, 1'b1, 1'b0);
        jump(1'b1, 16'h0000, 16'h0100);
        check_all("ja_f2", 16'h0100, 1'b0, 1'b1, 1'b0);
        step();
        check_all("ja_f3", 16'h0100, 1'b0, 1'b1, 1'b0);
        step();
        check_all("ja_run", 16'h0100, 1'b1, 1'b0, 1'b0);

        // Stall holds; all-ones wraps to zero
        jump(1'b1, 16'h0000, 16'hFFFF);
        step();
        step();
        check_all("wrap_run", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        stall_i = 1'b1;
        step();
        check_all("stall1", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        step();
        check_all("stall2", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        stall_i = 1'b0;
        step();
        check_all("wrap0", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Jump accepted while stalled
        stall_i = 1'b1;
        jump(1'b1, 16'h0000, 16'h0020);
        stall_i = 1'b0;
        check_all("jstall", 16'h0020, 1'b0, 1'b1, 1'b0);
        step();
        step();
        check_all("h_pre", 16'h0020, 1'b1, 1'b0, 1'b0);

        // Halt together with a jump: jump discarded, address frozen
        halt_i = 1'b1;
        jump(1'b1, 16'h0000, 16'h0055);
        halt_i = 1'b0;
        check_all("halt", 16'h0020, 1'b0, 1'b0, 1'b1);
        jump(1'b1, 16'h0000, 16'h0077);
        check_all("halt_ign", 16'h0020, 1'b0, 1'b0, 1'b1);
        resume_i = 1'b1;
        step();
        resume_i = 1'b0;
        check_all("resume", 16'h0020, 1'b1, 1'b0, 1'b0);
        step();
        check_all("resume_inc", 16'h0021, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset during FLUSH
        jump(1'b1, 16'h0000, 16'h0300);
        check_all("rf_pre", 16'h0300, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_all("rst_flush", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_all("rf_post", 16'h0001, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset during HALT
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        check_all("rh_pre", 16'h0001, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_all("rst_halt", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_all("rh_post", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
